parity_disp_drv: RTL and testbench

Display stage directly downstream of the serial parity generator. Captures each finished result (parity flag plus 5-bit ones count) on a one-cycle strobe and holds it. Drives the board's four-digit multiplexed seven-segment display: "EE" or "oo" on the left two digits, the decimal count on the right two. A "new result" decimal-point flash follows every capture.

---
 rtl/parity_disp_drv.sv | 132 +++++++++++++
 tb/tb_parity_disp_drv.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/parity_disp_drv.sv
// Display driver for the parity generator result. Each captured result is held and shown on a
// four-digit multiplexed seven-segment display as "EE"/"oo" plus the decimal ones count.
module parity_disp_drv #(
  parameter int DIG_CYCLES   = 100000,
  parameter int FRESH_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       valid,
  input  logic       par,
  input  logic [4:0] cnt,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int DW = $clog2(DIG_CYCLES);
  localparam int FW = $clog2(FRESH_CYCLES + 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(DIG_CYCLES - 1);
  localparam logic [FW-1:0] FRESH_LOAD = FW'(FRESH_CYCLES);

  // Active-low segment codes, bit order g..a.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_O     = 7'b0100011;

  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          have_q, have_d;
  logic          par_q, par_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    an_q, an_d;

  logic [1:0]    tens;
  logic [3:0]    units;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = 7'b1000000;
      4'd1:    digit_seg = 7'b1111001;
      4'd2:    digit_seg = 7'b0100100;
      4'd3:    digit_seg = 7'b0110000;
      4'd4:    digit_seg = 7'b0011001;
      4'd5:    digit_seg = 7'b0010010;
      4'd6:    digit_seg = 7'b0000010;
      4'd7:    digit_seg = 7'b1111000;
      4'd8:    digit_seg = 7'b0000000;
      4'd9:    digit_seg = 7'b0010000;
      default: digit_seg = SEG_BLANK;
    endcase
  endfunction

  // Scan, result capture and freshness timer.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    dcnt_d = dcnt_q + DW'(1);
    idx_d  = idx_q;
    if (dcnt_q == DIG_LAST) begin
      dcnt_d = '0;
      idx_d  = idx_q + 2'd1;
    end

    have_d = have_q;
    par_d  = par_q;
    cnt_d  = cnt_q;
    fcnt_d = (fcnt_q != '0) ? fcnt_q - FW'(1) : fcnt_q;
    if (valid) begin
      have_d = 1'b1;
      par_d  = par;
      cnt_d  = cnt;
      fcnt_d = FRESH_LOAD;
    end
  end

  // Binary to two decimal digits; the count never exceeds 31.
  always_comb begin
    tens = 2'd0;
    if (cnt_q >= 5'd30)      tens = 2'd3;
    else if (cnt_q >= 5'd20) tens = 2'd2;
    else if (cnt_q >= 5'd10) tens = 2'd1;
    units = 4'(cnt_q - 5'd10 * {3'b000, tens});
  end

  // Registered display drive, derived from the state held before this edge.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (have_q) begin
      an_d = ~(4'b0001 << idx_q);
      case (idx_q)
        2'd0:    seg_d = digit_seg(units);
        2'd1:    seg_d = (tens == 2'd0) ? SEG_BLANK : digit_seg({2'b00, tens});
        default: seg_d = par_q ? SEG_O : SEG_E;
      endcase
      dp_d = !((idx_q == 2'd3) && (fcnt_q != '0));
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      dcnt_q <= '0;
      idx_q  <= 2'd0;
      fcnt_q <= '0;
      have_q <= 1'b0;
      par_q  <= 1'b0;
      cnt_q  <= 5'd0;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
      an_q   <= 4'b1111;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      dcnt_q <= dcnt_d;
      idx_q  <= idx_d;
      fcnt_q <= fcnt_d;
      have_q <= have_d;
      par_q  <= par_d;
      cnt_q  <= cnt_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_parity_disp_drv.sv
// Self-checking bench for parity_disp_drv: directed and random captures compared every cycle
// against a model that derives the display from edge counts and the last capture time.
module tb_parity_disp_drv;

  localparam int DIG   = 4;
  localparam int FRESH = 40;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] LET_E = 7'b0000110;
  localparam logic [6:0] LET_O = 7'b0100011;

  logic       clk = 1'b0;
  logic       clr;
  logic       valid;
  logic       par;
  logic [4:0] cnt;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  parity_disp_drv #(.DIG_CYCLES(DIG), .FRESH_CYCLES(FRESH)) dut (
    .clk(clk), .clr(clr), .valid(valid), .par(par), .cnt(cnt),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int k     = 0;  // rising edges since reset release

  // Result held after edge k (cur) and after edge k-1 (prev).
  bit cur_have, prev_have, cur_par, prev_par;
  int cur_cnt, prev_cnt, cur_last, prev_last;

  logic [6:0] digit_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    cur_have = 0; prev_have = 0; cur_par = 0; prev_par = 0;
    cur_cnt = 0;  prev_cnt = 0;  cur_last = 0; prev_last = 0;
  endtask

  task automatic expect_outputs(input string tag);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int         slot;
    e_an = 4'b1111; e_seg = BLANK; e_dp = 1'b1;
    if (prev_have) begin
      slot = ((k - 1) / DIG) % 4;
      e_an = ~(4'b0001 << slot);
      if (slot == 0)      e_seg = digit_tab[prev_cnt % 10];
      else if (slot == 1) e_seg = (prev_cnt >= 10) ? digit_tab[prev_cnt / 10] : BLANK;
      else                e_seg = prev_par ? LET_O : LET_E;
      e_dp = !(slot == 3 && (k - 1 - prev_last) < FRESH);
    end
    check({tag, "_an"},  {3'b000, an}, {3'b000, e_an});
    check({tag, "_seg"}, seg, e_seg);
    check({tag, "_dp"},  {6'b0, dp}, {6'b0, e_dp});
  endtask

  task automatic step(input bit v, input bit p, input int c, input string tag);
    valid = v; par = p; cnt = 5'(c);
    @(posedge clk);
    #1;
    k++;
    prev_have = cur_have; prev_par = cur_par; prev_cnt = cur_cnt; prev_last = cur_last;
    if (v) begin
      cur_have = 1; cur_par = p; cur_cnt = c; cur_last = k;
    end
    expect_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, 0, 0, tag);
  endtask

  initial begin
    clr = 1'b1; valid = 1'b0; par = 1'b0; cnt = 5'd0;
    model_reset();
    #12;
    expect_outputs("reset");
    clr = 1'b0;

    idle(10, "dark");

    step(1, 1, 7, "cap_o7");
    idle(50, "show_o7");

    step(1, 0, 16, "cap_e16");
    idle(16, "show_e16");

    step(1, 1, 0, "cap_0");
    idle(16, "show_0");
    step(1, 0, 31, "cap_31");
    idle(16, "show_31");
    step(1, 1, 10, "cap_10");
    idle(16, "show_10");

    step(1, 1, 5, "cap_o5");
    idle(19, "show_o5");
    step(1, 0, 2, "cap_e2");
    idle(50, "show_e2");

    step(1, 0, 19, "cap_multi");
    step(1, 0, 19, "cap_multi");
    step(1, 0, 19, "cap_multi");
    idle(8, "show_multi");

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 31), "rand");

    // Clear mid-slot, away from any edge: outputs must go dark without waiting for a clock.
    #2;
    clr = 1'b1;
    #1;
    check("clr_async_an",  {3'b000, an}, 7'b0001111);
    check("clr_async_seg", seg, BLANK);
    check("clr_async_dp",  {6'b0, dp}, 7'b0000001);
    valid = 1'b1; par = 1'b1; cnt = 5'd9;
    @(posedge clk);
    #1;
    check("clr_hold_an",  {3'b000, an}, 7'b0001111);
    check("clr_hold_seg", seg, BLANK);
    check("clr_hold_dp",  {6'b0, dp}, 7'b0000001);
    valid = 1'b0;
    clr   = 1'b0;
    model_reset();

    idle(10, "post_clr_dark");
    step(1, 0, 23, "cap_after_clr");
    idle(45, "show_after_clr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
